// File: rtl/frag_wr_arbiter_rr_if.sv
// rtl/frag_wr_arbiter_rr_if.sv - fragment FIFO and main-memory write bus for frag_wr_arbiter_rr
interface frag_wr_arbiter_rr_if #(
    parameter int NUM_CHANNELS        = 4,
    parameter int DATA_WIDTH          = 32,
    parameter int MAIN_MEM_ADDR_WIDTH = 32
);
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] frag_fifo_rd_data;
    logic [NUM_CHANNELS-1:0]            frag_fifo_empty;
    logic [NUM_CHANNELS-1:0]            frag_fifo_threshold;
    logic [NUM_CHANNELS-1:0]            frag_fifo_rd_en;
    logic [DATA_WIDTH-1:0]              mem_wr_data;
    logic [MAIN_MEM_ADDR_WIDTH-1:0]     mem_wr_addr;
    logic                               mem_wr_en;
    logic                               mem_wr_ready;

    modport master (
        input  frag_fifo_rd_data,
        input  frag_fifo_empty,
        input  frag_fifo_threshold,
        input  mem_wr_ready,
        output frag_fifo_rd_en,
        output mem_wr_data,
        output mem_wr_addr,
        output mem_wr_en
    );

    modport slave (
        output frag_fifo_rd_data,
        output frag_fifo_empty,
        output frag_fifo_threshold,
        output mem_wr_ready,
        input  frag_fifo_rd_en,
        input  mem_wr_data,
        input  mem_wr_addr,
        input  mem_wr_en
    );
endinterface

// File: rtl/frag_wr_arbiter_rr.sv
// rtl/frag_wr_arbiter_rr.sv - round-robin fragment write arbiter draining per-pipe FIFOs to main memory
module frag_wr_arbiter_rr #(
    parameter int NUM_CHANNELS                = 4,
    parameter int DATA_WIDTH                  = 32,
    parameter int MAIN_MEM_ADDR_WIDTH         = 32,
    parameter int LOCAL_VERTEX_MEM_ADDR_WIDTH = 4,
    parameter int FRAG_COUNT_WIDTH            = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   en,
    input  logic                                   start,
    input  logic                                   flush,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0]         f_array_ptr,
    input  logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] vertexSize,
    input  logic [NUM_CHANNELS-1:0]                channel_mask,
    frag_wr_arbiter_rr_if.master                   bus,
    output logic                                   busy,
    output logic                                   done,
    output logic [FRAG_COUNT_WIDTH-1:0]            frag_count,
    output logic                                   stranded
);
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RD,
        S_CAP,
        S_WR
    } state_t;

    state_t                                 state_q, state_d;
    logic [CH_W-1:0]                        last_grant_q, last_grant_d;
    logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] words_left_q, words_left_d;
    logic [MAIN_MEM_ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic                                   flush_pending_q, flush_pending_d;
    logic [FRAG_COUNT_WIDTH-1:0]            frag_count_q, frag_count_d;
    logic                                   stranded_q, stranded_d;
    logic                                   done_q, done_d;
    logic                                   mem_wr_en_q, mem_wr_en_d;
    logic [DATA_WIDTH-1:0]                  mem_wr_data_q, mem_wr_data_d;
    logic [MAIN_MEM_ADDR_WIDTH-1:0]         mem_wr_addr_q, mem_wr_addr_d;

    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] elig_shift;
    logic                    arb_found;
    logic [CH_W-1:0]         arb_idx;
    int                      cand;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic [NUM_CHANNELS-1:0] rd_en;

    assign eligible = channel_mask & bus.frag_fifo_threshold;

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = last_grant_q;
        cand       = 0;
        elig_shift = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            cand       = (int'(last_grant_q) + k) % NUM_CHANNELS;
            elig_shift = eligible >> cand;
            if (!arb_found && elig_shift[0]) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'(cand);
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (last_grant_q == CH_W'(i)) begin
                grant_data = bus.frag_fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pop is suppressed on an empty FIFO; the upstream underflow flag reports that fault.
    always_comb begin
        rd_en = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            rd_en[i] = en && (state_q == S_RD) && (last_grant_q == CH_W'(i))
                       && !bus.frag_fifo_empty[i];
        end
    end

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        words_left_d    = words_left_q;
        wr_addr_d       = wr_addr_q;
        flush_pending_d = flush_pending_q;
        frag_count_d    = frag_count_q;
        stranded_d      = stranded_q;
        done_d          = 1'b0;
        mem_wr_en_d     = mem_wr_en_q;
        mem_wr_data_d   = mem_wr_data_q;
        mem_wr_addr_d   = mem_wr_addr_q;

        if (en) begin
            if (state_q != S_IDLE && flush) begin
                flush_pending_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        wr_addr_d       = f_array_ptr;
                        frag_count_d    = '0;
                        stranded_d      = 1'b0;
                        flush_pending_d = 1'b0;
                        state_d         = S_ARB;
                    end
                end

                S_ARB: begin
                    if (arb_found) begin
                        last_grant_d = arb_idx;
                        words_left_d = vertexSize;
                        state_d      = S_RD;
                    end else if (flush_pending_q) begin
                        stranded_d      = stranded_q | (|(channel_mask & ~bus.frag_fifo_empty));
                        done_d          = 1'b1;
                        flush_pending_d = 1'b0;
                        state_d         = S_IDLE;
                    end
                end

                S_RD: begin
                    state_d = S_CAP;
                end

                S_CAP: begin
                    mem_wr_data_d = grant_data;
                    mem_wr_addr_d = wr_addr_q;
                    mem_wr_en_d   = 1'b1;
                    state_d       = S_WR;
                end

                S_WR: begin
                    if (mem_wr_en_q && bus.mem_wr_ready) begin
                        mem_wr_en_d = 1'b0;
                        wr_addr_d   = wr_addr_q + MAIN_MEM_ADDR_WIDTH'(1);
                        if (words_left_q == '0) begin
                            if (frag_count_q != '1) begin
                                frag_count_d = frag_count_q + FRAG_COUNT_WIDTH'(1);
                            end
                            state_d = S_ARB;
                        end else begin
                            words_left_d = words_left_q - LOCAL_VERTEX_MEM_ADDR_WIDTH'(1);
                            state_d      = S_RD;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            last_grant_q    <= CH_W'(NUM_CHANNELS - 1);
            words_left_q    <= '0;
            wr_addr_q       <= '0;
            flush_pending_q <= 1'b0;
            frag_count_q    <= '0;
            stranded_q      <= 1'b0;
            done_q          <= 1'b0;
            mem_wr_en_q     <= 1'b0;
            mem_wr_data_q   <= '0;
            mem_wr_addr_q   <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            words_left_q    <= words_left_d;
            wr_addr_q       <= wr_addr_d;
            flush_pending_q <= flush_pending_d;
            frag_count_q    <= frag_count_d;
            stranded_q      <= stranded_d;
            done_q          <= done_d;
            mem_wr_en_q     <= mem_wr_en_d;
            mem_wr_data_q   <= mem_wr_data_d;
            mem_wr_addr_q   <= mem_wr_addr_d;
        end
    end

    assign bus.frag_fifo_rd_en = rd_en;
    assign bus.mem_wr_en       = mem_wr_en_q;
    assign bus.mem_wr_data     = mem_wr_data_q;
    assign bus.mem_wr_addr     = mem_wr_addr_q;
    assign busy                = (state_q != S_IDLE);
    assign done                = done_q;
    assign frag_count          = frag_count_q;
    assign stranded            = stranded_q;
endmodule

// File: tb/tb_frag_wr_arbiter_rr.sv
// tb/tb_frag_wr_arbiter_rr.sv - directed self-checking bench for frag_wr_arbiter_rr
module tb_frag_wr_arbiter_rr;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          reset, en, start, flush, ready;
    logic [AW-1:0] f_array_ptr;
    logic [LW-1:0] vertexSize;
    logic [NC-1:0] channel_mask;
    logic          busy, done, stranded;
    logic [FW-1:0] frag_count;

    int errors = 0;
    int checks = 0;

    frag_wr_arbiter_rr_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .MAIN_MEM_ADDR_WIDTH(AW)) bus ();

    frag_wr_arbiter_rr #(
        .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .MAIN_MEM_ADDR_WIDTH(AW),
        .LOCAL_VERTEX_MEM_ADDR_WIDTH(LW), .FRAG_COUNT_WIDTH(FW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .flush(flush),
        .f_array_ptr(f_array_ptr), .vertexSize(vertexSize), .channel_mask(channel_mask),
        .bus(bus), .busy(busy), .done(done), .frag_count(frag_count), .stranded(stranded)
    );

    always #5 clk = ~clk;

    // FIFO model: pushes from tasks, pops on rd_en with one-cycle read latency.
    logic [DW-1:0]    fmem [NC][256];
    int               tail [NC];
    int               head [NC];
    int               mrd [NC];
    int               pushed [NC];
    int               rd_cnt [NC];
    logic [DW-1:0]    rd_data_r [NC];
    logic [NC*DW-1:0] rdd;
    logic [NC-1:0]    emp, thr;

    always_comb begin
        rdd = '0;
        emp = '0;
        thr = '0;
        for (int i = 0; i < NC; i++) begin
            rdd[i*DW +: DW] = rd_data_r[i];
            emp[i] = (tail[i] == head[i]);
            thr[i] = (tail[i] - head[i]) > int'(vertexSize);
        end
    end

    assign bus.frag_fifo_rd_data   = rdd;
    assign bus.frag_fifo_empty     = emp;
    assign bus.frag_fifo_threshold = thr;
    assign bus.mem_wr_ready        = ready;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (bus.frag_fifo_rd_en[i]) begin
                rd_data_r[i] <= fmem[i][head[i]];
                head[i]      <= head[i] + 1;
                rd_cnt[i]    <= rd_cnt[i] + 1;
            end
        end
    end

    logic [AW-1:0] wa [512];
    logic [DW-1:0] wd [512];
    int wcount = 0;
    int viol = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (!reset && en && bus.mem_wr_en && ready) begin
            wa[wcount] <= bus.mem_wr_addr;
            wd[wcount] <= bus.mem_wr_data;
            wcount     <= wcount + 1;
        end
        if (((bus.frag_fifo_rd_en & emp) != '0) || ($countones(bus.frag_fifo_rd_en) > 1))
            viol <= viol + 1;
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    logic [DW-1:0] exp_q [$];

    function automatic logic [DW-1:0] word_of(input int ch, input int n);
        return {4'hA, 4'(ch), 8'h00, 16'(n)};
    endfunction

    task automatic push_words(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            fmem[ch][tail[ch]] = word_of(ch, pushed[ch]);
            pushed[ch]++;
            tail[ch]++;
        end
    endtask

    task automatic expect_frag(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(fmem[ch][mrd[ch]]);
            mrd[ch]++;
        end
    endtask

    task automatic wait_writes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (wcount >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_wr_en(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.mem_wr_en === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic start_session(input logic [AW-1:0] ptr);
        @(negedge clk);
        f_array_ptr = ptr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; start = 1'b0; flush = 1'b0; ready = 1'b1;
        f_array_ptr = '0; vertexSize = '0; channel_mask = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (frag_count !== '0) begin errors++; $display("FAIL reset_frag_count got %0d want 0", frag_count); end
        checks++; if (stranded !== 1'b0) begin errors++; $display("FAIL reset_stranded got %0b want 0", stranded); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", bus.mem_wr_en); end
        checks++; if (bus.mem_wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %0h want 0", bus.mem_wr_addr); end
        checks++; if (bus.mem_wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %0h want 0", bus.mem_wr_data); end
        checks++; if (bus.frag_fifo_rd_en !== '0) begin errors++; $display("FAIL reset_rd_en got %0h want 0", bus.frag_fifo_rd_en); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy got %0b want 0", busy); end
    endtask

    task automatic test_single_channel();
        int base, d0; bit ok;
        do_reset();
        channel_mask = 4'b0001; vertexSize = 4'd3; ready = 1'b1;
        base = wcount;
        push_words(0, 8);
        expect_frag(0, 4); expect_frag(0, 4);
        start_session(32'h100);
        wait_writes(base + 8, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d writes want 8", wcount - base); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (wa[base+k] !== 32'h100 + k) begin errors++; $display("FAIL single_addr[%0d] got %0h want %0h", k, wa[base+k], 32'h100 + k); end
            checks++; if (wd[base+k] !== exp_q[k]) begin errors++; $display("FAIL single_data[%0d] got %0h want %0h", k, wd[base+k], exp_q[k]); end
        end
        checks++; if (frag_count !== 16'd2) begin errors++; $display("FAIL single_frag_count got %0d want 2", frag_count); end
        d0 = done_cnt;
        pulse_flush();
        wait_done(d0 + 1, 20, ok);
        repeat (3) @(negedge clk);
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_done got %0b want 0", busy); end
        checks++; if (stranded !== 1'b0) begin errors++; $display("FAIL single_stranded got %0b want 0", stranded); end
    endtask

    task automatic test_round_robin();
        int base, d0; bit ok;
        do_reset();
        channel_mask = 4'b1111; vertexSize = 4'd1; ready = 1'b1;
        base = wcount;
        for (int c = 0; c < 4; c++) push_words(c, 2);
        for (int c = 0; c < 4; c++) expect_frag(c, 2);
        start_session(32'h100);
        wait_writes(base + 8, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_first_timeout got %0d writes want 8", wcount - base); end
        push_words(1, 2); push_words(3, 2);
        expect_frag(1, 2); expect_frag(3, 2);
        wait_writes(base + 12, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_second_timeout got %0d writes want 12", wcount - base); end
        for (int k = 0; k < 12; k++) begin
            checks++; if (wa[base+k] !== 32'h100 + k) begin errors++; $display("FAIL rr_addr[%0d] got %0h want %0h", k, wa[base+k], 32'h100 + k); end
            checks++; if (wd[base+k] !== exp_q[k]) begin errors++; $display("FAIL rr_data[%0d] got %0h want %0h", k, wd[base+k], exp_q[k]); end
        end
        checks++; if (frag_count !== 16'd6) begin errors++; $display("FAIL rr_frag_count got %0d want 6", frag_count); end
        d0 = done_cnt;
        pulse_flush();
        wait_done(d0 + 1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_done_timeout got %0d want %0d", done_cnt, d0 + 1); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rr_rd_en_violations got %0d want 0", viol); end
    endtask

    task automatic test_backpressure();
        int base, d0, rc; bit ok;
        do_reset();
        channel_mask = 4'b0001; vertexSize = 4'd2; ready = 1'b1;
        base = wcount;
        push_words(0, 3);
        expect_frag(0, 3);
        start_session(32'h200);
        wait_writes(base + 1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_first_timeout got %0d want 1", wcount - base); end
        ready = 1'b0;
        wait_wr_en(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_wr_en_timeout got 0 want 1"); end
        rc = rd_cnt[0];
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.mem_wr_en !== 1'b1) begin errors++; $display("FAIL bp_stall_en[%0d] got %0b want 1", i, bus.mem_wr_en); end
            checks++; if (bus.mem_wr_addr !== 32'h201) begin errors++; $display("FAIL bp_stall_addr[%0d] got %0h want 201", i, bus.mem_wr_addr); end
            checks++; if (bus.mem_wr_data !== exp_q[1]) begin errors++; $display("FAIL bp_stall_data[%0d] got %0h want %0h", i, bus.mem_wr_data, exp_q[1]); end
            checks++; if (rd_cnt[0] !== rc) begin errors++; $display("FAIL bp_stall_rd[%0d] got %0d want %0d", i, rd_cnt[0], rc); end
            @(negedge clk);
        end
        ready = 1'b1;
        wait_writes(base + 3, 50, ok);
        repeat (5) @(negedge clk);
        checks++; if (wcount !== base + 3) begin errors++; $display("FAIL bp_write_count got %0d want 3", wcount - base); end
        for (int k = 1; k < 3; k++) begin
            checks++; if (wa[base+k] !== 32'h200 + k) begin errors++; $display("FAIL bp_addr[%0d] got %0h want %0h", k, wa[base+k], 32'h200 + k); end
            checks++; if (wd[base+k] !== exp_q[k]) begin errors++; $display("FAIL bp_data[%0d] got %0h want %0h", k, wd[base+k], exp_q[k]); end
        end
        d0 = done_cnt;
        pulse_flush();
        wait_done(d0 + 1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got %0d want %0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_mask();
        int base, d0, r1; bit ok;
        do_reset();
        channel_mask = 4'b0101; vertexSize = 4'd1; ready = 1'b1;
        base = wcount;
        r1 = rd_cnt[1];
        push_words(1, 2); push_words(0, 4);
        expect_frag(0, 4); expect_frag(1, 2);
        start_session(32'h300);
        wait_writes(base + 3, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mask_timeout got %0d want 3", wcount - base); end
        checks++; if (rd_cnt[1] !== r1) begin errors++; $display("FAIL mask_ch1_read got %0d want %0d", rd_cnt[1], r1); end
        channel_mask = 4'b0111;
        wait_writes(base + 6, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mask_unmask_timeout got %0d want 6", wcount - base); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (wa[base+k] !== 32'h300 + k) begin errors++; $display("FAIL mask_addr[%0d] got %0h want %0h", k, wa[base+k], 32'h300 + k); end
            checks++; if (wd[base+k] !== exp_q[k]) begin errors++; $display("FAIL mask_data[%0d] got %0h want %0h", k, wd[base+k], exp_q[k]); end
        end
        checks++; if (frag_count !== 16'd3) begin errors++; $display("FAIL mask_frag_count got %0d want 3", frag_count); end
        d0 = done_cnt;
        pulse_flush();
        wait_done(d0 + 1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mask_done_timeout got %0d want %0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_enable_and_reset();
        int base, wc, rc; bit ok;
        do_reset();
        channel_mask = 4'b0001; vertexSize = 4'd1; ready = 1'b1;
        base = wcount;
        push_words(0, 4);
        expect_frag(0, 2);
        start_session(32'h400);
        wait_wr_en(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL en_wr_en_timeout got 0 want 1"); end
        en = 1'b0;
        wc = wcount;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.mem_wr_en !== 1'b1) begin errors++; $display("FAIL en_hold_wr_en[%0d] got %0b want 1", i, bus.mem_wr_en); end
            checks++; if (bus.mem_wr_addr !== 32'h400) begin errors++; $display("FAIL en_hold_addr[%0d] got %0h want 400", i, bus.mem_wr_addr); end
            checks++; if (bus.mem_wr_data !== exp_q[0]) begin errors++; $display("FAIL en_hold_data[%0d] got %0h want %0h", i, bus.mem_wr_data, exp_q[0]); end
            checks++; if (wcount !== wc) begin errors++; $display("FAIL en_hold_accept[%0d] got %0d want %0d", i, wcount, wc); end
            @(negedge clk);
        end
        en = 1'b1;
        wait_writes(base + 1, 20, ok);
        rc = rd_cnt[0];
        en = 1'b0;
        #1;
        checks++; if (bus.frag_fifo_rd_en !== '0) begin errors++; $display("FAIL en_rd_en_forced got %0h want 0", bus.frag_fifo_rd_en); end
        repeat (2) @(negedge clk);
        checks++; if (rd_cnt[0] !== rc) begin errors++; $display("FAIL en_frozen_pop got %0d want %0d", rd_cnt[0], rc); end
        en = 1'b1;
        wait_writes(base + 2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL en_resume_timeout got %0d want 2", wcount - base); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (wa[base+k] !== 32'h400 + k) begin errors++; $display("FAIL en_addr[%0d] got %0h want %0h", k, wa[base+k], 32'h400 + k); end
            checks++; if (wd[base+k] !== exp_q[k]) begin errors++; $display("FAIL en_data[%0d] got %0h want %0h", k, wd[base+k], exp_q[k]); end
        end
        checks++; if (frag_count !== 16'd1) begin errors++; $display("FAIL en_frag_count got %0d want 1", frag_count); end
        wait_writes(base + 3, 20, ok);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
        checks++; if (frag_count !== '0) begin errors++; $display("FAIL midreset_frag_count got %0d want 0", frag_count); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL midreset_wr_en got %0b want 0", bus.mem_wr_en); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (wcount !== base + 3) begin errors++; $display("FAIL midreset_extra_writes got %0d want 3", wcount - base); end
    endtask

    task automatic test_flush_stranded();
        int base, d0, r2; bit ok;
        do_reset();
        channel_mask = 4'b0100; vertexSize = 4'd3; ready = 1'b1;
        base = wcount;
        r2 = rd_cnt[2];
        push_words(2, 2);
        d0 = done_cnt;
        pulse_flush();
        start_session(32'h500);
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL strand_busy_before_flush got %0b want 1", busy); end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL strand_idle_flush_done got %0d want 0", done_cnt - d0); end
        pulse_flush();
        wait_done(d0 + 1, 20, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL strand_done_timeout got %0d want %0d", done_cnt, d0 + 1); end
        checks++; if (stranded !== 1'b1) begin errors++; $display("FAIL strand_flag got %0b want 1", stranded); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL strand_busy got %0b want 0", busy); end
        checks++; if (frag_count !== '0) begin errors++; $display("FAIL strand_frag_count got %0d want 0", frag_count); end
        checks++; if (rd_cnt[2] !== r2) begin errors++; $display("FAIL strand_ch2_read got %0d want %0d", rd_cnt[2], r2); end
        checks++; if (wcount !== base) begin errors++; $display("FAIL strand_writes got %0d want 0", wcount - base); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL strand_rd_en_violations got %0d want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_enable_and_reset();
        test_flush_stranded();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
